// File: rtl/pc_fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int PC_AW = 8;
  localparam int PC_DW = 8;

  localparam logic [PC_AW-1:0] PC_RESET_PC = 8'h00;
  localparam logic [PC_DW-1:0] PC_HALT_OP  = 8'hFF;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory read port: request/address out of the fetcher, strobe/data back.
interface pc_fetch_if
  import pc_fetch_pkg::*;
#(
  parameter int AW = PC_AW,
  parameter int DW = PC_DW
);

  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [DW-1:0] mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_valid,
    output mem_data
  );

endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory, hands each
// word to the downstream instruction register, then waits for execute to finish.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int               AW       = PC_AW,
  parameter int               DW       = PC_DW,
  parameter logic [AW-1:0]    RESET_PC = PC_RESET_PC,
  parameter logic [DW-1:0]    HALT_OP  = PC_HALT_OP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                exec_done,
  input  logic                br_taken,
  input  logic [AW-1:0]       br_target,
  pc_fetch_if.master          mem,
  output logic [DW-1:0]       ir_d,
  output logic                ir_en,
  output logic [AW-1:0]       pc,
  output logic                busy,
  output logic                halted
);

  localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

  state_t state;

  // Memory request and status flags decode straight from state, so an
  // asynchronous reset drops mem_rd in the same instant it lands.
  assign mem.mem_rd   = (state == S_FETCH);
  assign mem.mem_addr = pc;
  assign busy         = (state == S_FETCH) || (state == S_EXEC);
  assign halted       = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir_d  <= '0;
      ir_en <= 1'b0;
    end else begin
      ir_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.mem_valid) begin
            ir_d  <= mem.mem_data;
            ir_en <= 1'b1;
            state <= (mem.mem_data == HALT_OP) ? S_HALT : S_EXEC;
          end
        end
        S_EXEC: begin
          // stall outranks exec_done; PC wraps naturally at 2^AW
          if (exec_done && !stall) begin
            pc    <= br_taken ? br_target : pc + PC_STEP;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomized checks of pc_fetch against a behavioural fetch/execute model.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       exec_done = 1'b0;
  logic       br_taken = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic [7:0] ir_d;
  logic       ir_en;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  pc_fetch_if #(.AW(8), .DW(8)) mif ();

  pc_fetch #(.AW(8), .DW(8), .RESET_PC(8'h00), .HALT_OP(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .exec_done (exec_done),
    .br_taken  (br_taken),
    .br_target (br_target),
    .mem       (mif),
    .ir_d      (ir_d),
    .ir_en     (ir_en),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // behavioural model
  bit m_fetch, m_exec, m_halt, m_iren;
  int m_pc, m_ir, wcnt;
  int imem [256];

  // stimulus knobs
  int         lat = 0;
  bit         k_ed, k_st, k_start, k_bt, k_spur;
  logic [7:0] k_tgt = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 0; m_exec = 0; m_halt = 0; m_iren = 0;
    m_pc = 0; m_ir = 0; wcnt = 0;
  endtask

  task automatic model_edge();
    m_iren = 0;
    if (m_halt) begin
      m_halt = 1;
    end else if (m_fetch) begin
      if (mif.mem_valid) begin
        m_ir = int'(mif.mem_data);
        m_iren = 1;
        m_fetch = 0;
        if (mif.mem_data == 8'hFF) m_halt = 1;
        else m_exec = 1;
      end else begin
        wcnt++;
      end
    end else if (m_exec) begin
      if (exec_done && !stall) begin
        m_pc = br_taken ? int'(br_target) : (m_pc + 1) % 256;
        m_exec = 0; m_fetch = 1; wcnt = 0;
      end
    end else if (start) begin
      m_fetch = 1; wcnt = 0;
    end
  endtask

  task automatic drive();
    start = k_start;
    stall = k_st;
    exec_done = k_ed;
    br_taken = k_bt;
    br_target = k_tgt;
    mif.mem_valid = (m_fetch && wcnt >= lat) || (k_spur && !m_fetch);
    mif.mem_data = m_fetch ? 8'(imem[m_pc]) : 8'($urandom);
  endtask

  task automatic check_all();
    chk("pc",       32'(pc),           32'(m_pc));
    chk("mem_addr", 32'(mif.mem_addr), 32'(m_pc));
    chk("mem_rd",   32'(mif.mem_rd),   32'(m_fetch));
    chk("busy",     32'(busy),         32'(m_fetch | m_exec));
    chk("halted",   32'(halted),       32'(m_halt));
    chk("ir_en",    32'(ir_en),        32'(m_iren));
    chk("ir_d",     32'(ir_d),         32'(m_ir));
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int cnt_rd, cnt_en, guard;
    for (int i = 0; i < 256; i++) imem[i] = int'($urandom_range(0, 254));
    mif.mem_valid = 1'b0;
    mif.mem_data = 8'h00;
    model_reset();

    // power-on reset
    #1 reset = 1'b0;
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;

    // zero-wait run: 0x11, 0x22 at addresses 0 and 1
    imem[0] = 8'h11; imem[1] = 8'h22;
    k_start = 1; k_ed = 1; lat = 0;
    cycle();
    k_start = 0;
    chk("zw_rd0", 32'(mif.mem_rd), 32'd1);
    cycle();
    chk("zw_ir0", 32'(ir_d), 32'h11);
    chk("zw_en0", 32'(ir_en), 32'd1);
    cycle();
    chk("zw_addr1", 32'(mif.mem_addr), 32'd1);
    cycle();
    chk("zw_ir1", 32'(ir_d), 32'h22);
    cycle();
    chk("zw_addr2", 32'(mif.mem_addr), 32'd2);

    // reach EXEC at pc 5, then reset asynchronously
    guard = 0;
    while (!(m_pc == 5 && m_exec) && guard < 40) begin cycle(); guard++; end
    chk("reach_pc5", 32'(guard < 40), 32'd1);
    async_reset();
    chk("rst_pc", 32'(pc), 32'h00);
    k_start = 1;
    cycle();
    k_start = 0;
    chk("restart_addr", 32'(mif.mem_addr), 32'h00);

    // 3-cycle memory latency, spurious strobe while executing
    lat = 3; k_ed = 0; k_spur = 1;
    cnt_rd = int'(mif.mem_rd); cnt_en = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      cnt_rd += int'(mif.mem_rd);
      cnt_en += int'(ir_en);
    end
    chk("lat_rd_cycles", 32'(cnt_rd), 32'd4);
    chk("lat_ir_pulses", 32'(cnt_en), 32'd1);

    // branch to 0x40
    lat = 0; k_spur = 0; k_ed = 1; k_bt = 1; k_tgt = 8'h40;
    cycle();
    k_bt = 0;
    chk("br_addr", 32'(mif.mem_addr), 32'h40);
    cycle();
    k_st = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", 32'(pc), 32'h40);
    end
    k_st = 0;
    cycle();
    chk("stall_resume_rd", 32'(mif.mem_rd), 32'd1);
    chk("stall_resume_pc", 32'(pc), 32'h41);

    // wrap from 0xFF
    imem[255] = 8'h33;
    k_bt = 1; k_tgt = 8'hFF;
    cycle();
    cycle();
    k_bt = 0;
    chk("wrap_pre", 32'(pc), 32'hFF);
    cycle();
    cycle();
    chk("wrap_pc", 32'(pc), 32'h00);

    // halt at 0x07
    imem[7] = 8'hFF;
    k_bt = 1; k_tgt = 8'h07;
    cycle();
    cycle();
    k_bt = 0;
    cycle();
    chk("halt_ir_d", 32'(ir_d), 32'hFF);
    chk("halt_ir_en", 32'(ir_en), 32'd1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc), 32'h07);
    k_spur = 1;
    for (int i = 0; i < 6; i++) begin
      k_start = (i % 2) == 0;
      cycle();
    end
    k_start = 0; k_spur = 0;
    chk("halt_sticky", 32'(halted), 32'd1);
    async_reset();

    // randomized phase
    for (int i = 0; i < 256; i++)
      imem[i] = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 254));
    for (int n = 0; n < 1500; n++) begin
      k_start = ($urandom_range(0, 3) == 0);
      k_ed    = ($urandom_range(0, 1) == 0);
      k_st    = ($urandom_range(0, 2) == 0);
      k_bt    = ($urandom_range(0, 3) == 0);
      k_tgt   = 8'($urandom);
      k_spur  = ($urandom_range(0, 3) == 0);
      if (!m_fetch) lat = int'($urandom_range(0, 3));
      cycle();
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
